mult_div_unit: RTL and testbench



---
 rtl/multdiv_pkg.sv | 16 +
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 tb/tb_mult_div_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared encodings for the multicycle MULT/DIV unit: FSM states, op select, default width.
package multdiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned MD_WIDTH = 32;

endpackage

// File: rtl/mult_div_unit.sv
// Signed shift-add multiplier / restoring divider, one bit per clock, sign fixed up at the end.
// Optional MULTDIV_EARLY_TERM_EN: MULT stops iterating once the remaining multiplier bits are zero.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned   CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               op_q;
  logic               neg_q;   // sign of product / quotient
  logic               rneg_q;  // sign of dividend, carried by the remainder
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplr_q;  // multiplier magnitude (MULT) or divisor magnitude (DIV)
  logic               busy_q, done_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] acc_mul_d, acc_div_d, prod_fix;
  logic [WIDTH-1:0]   rem_sh, quo_fix, rem_fix;
  logic [WIDTH:0]     trial;
  logic               last_iter;

  always_comb begin
    abs_a = a[WIDTH-1] ? ('0 - a) : a;
    abs_b = b[WIDTH-1] ? ('0 - b) : b;

    acc_mul_d = acc_q + (mplr_q[0] ? mcand_q : '0);

    // Remainder magnitude stays below the divisor (at most 2^(WIDTH-1)), so the shifted value fits WIDTH bits.
    rem_sh = acc_q[2*WIDTH-2:WIDTH-1];
    trial  = {1'b0, rem_sh} - {1'b0, mplr_q};
    if (!trial[WIDTH]) begin
      acc_div_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_div_d = {rem_sh, acc_q[WIDTH-2:0], 1'b0};
    end

    prod_fix = neg_q  ? ('0 - acc_q) : acc_q;
    quo_fix  = neg_q  ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULTDIV_EARLY_TERM_EN
    last_iter = (cnt_q == LAST) || ((op_q == OP_MULT) && (mplr_q[WIDTH-1:1] == '0));
`else
    last_iter = (cnt_q == LAST);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if ((op == OP_DIV) && (b == '0)) begin
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              op_q    <= op;
              neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
              rneg_q  <= a[WIDTH-1];
              cnt_q   <= '0;
              mplr_q  <= abs_b;
              busy_q  <= 1'b1;
              state_q <= S_ITER;
              if (op == OP_MULT) begin
                mcand_q <= {{WIDTH{1'b0}}, abs_a};
                acc_q   <= '0;
              end else begin
                mcand_q <= '0;
                acc_q   <= {{WIDTH{1'b0}}, abs_a};
              end
            end
          end
        end
        S_ITER: begin
          if (op_q == OP_MULT) begin
            acc_q   <= acc_mul_d;
            mcand_q <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplr_q  <= {1'b0, mplr_q[WIDTH-1:1]};
          end else begin
            acc_q <= acc_div_d;
          end
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) state_q <= S_FIX;
        end
        S_FIX: begin
          if (op_q == OP_MULT) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle plus hand-computed literal vectors.
module tb_mult_div_unit;

  localparam int unsigned W = 32;
`ifdef MULTDIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned cyc    = 0;

  // Reference model: outcome computed with plain 64-bit arithmetic, timing as edge numbers.
  bit          m_valid = 1'b0;
  bit          m_pend  = 1'b0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;
  int unsigned m_fin = 0, m_accept = 0;

  function automatic int unsigned iters(logic o, logic [31:0] bv);
    logic [31:0] mag;
    int unsigned n;
    mag = bv[31] ? -bv : bv;
    n = 1;
    for (int unsigned i = 0; i < 32; i++) if (mag[i]) n = i + 1;
    return (EARLY && o == 1'b0) ? n : W;
  endfunction

  function automatic logic [63:0] result(logic o, logic [31:0] av, logic [31:0] bv);
    longint sa, sb, p, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (o == 1'b0) begin
      p = sa * sb;
      return p;
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int unsigned lat(logic o, int unsigned n);
    return (EARLY && o == 1'b0) ? n + 1 : W + 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_valid = 1'b1; m_pend = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0;
      m_accept = cyc + 1;
    end else if (m_valid) begin
      m_done = 1'b0; m_dz = 1'b0;
      if (m_pend && cyc == m_fin) begin
        {m_hi, m_lo} = m_res;
        m_done = 1'b1; m_busy = 1'b0; m_pend = 1'b0;
        m_accept = cyc + 2;
      end else if (!m_pend && cyc >= m_accept && start) begin
        if (op == 1'b1 && b == '0) begin
          m_done = 1'b1; m_dz = 1'b1;
          m_accept = cyc + 2;
        end else begin
          m_pend = 1'b1; m_busy = 1'b1;
          m_fin = cyc + iters(op, b) + 1;
          m_res = result(op, a, b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      total++;
      if (busy !== m_busy || done !== m_done || div_zero !== m_dz || hi !== m_hi || lo !== m_lo)
        $display("FAIL cycle_model cyc=%0d busy=%b/%b done=%b/%b dz=%b/%b hi=%h/%h lo=%h/%h (got/exp)",
                 cyc, busy, m_busy, done, m_done, div_zero, m_dz, hi, m_hi, lo, m_lo);
      else passed++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", nm, got, exp);
    else passed++;
  endtask

  task automatic issue(input logic o, input logic [31:0] av, input logic [31:0] bv,
                       output int unsigned k);
    repeat (2) @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int unsigned e);
    e = 0;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin
        e = cyc;
        break;
      end
      @(negedge clk);
    end
    if (e == 0) begin
      total++;
      $display("FAIL %s_timeout got=no_done exp=done_within_200", nm);
    end
  endtask

  typedef struct {
    logic        o;
    logic [31:0] av, bv;
    logic [63:0] exp;
    int unsigned n;
  } vec_t;

  vec_t vecs[8] = '{
    '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32},
    '{1'b1, 32'd100,       -32'sd7,       64'h0000_0002_FFFF_FFF2, 0},
    '{1'b1, -32'sd100,     -32'sd7,       64'hFFFF_FFFE_0000_000E, 0},
    '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1},
    '{1'b0, 32'h1234_5678, 32'h0,         64'h0,                   1},
    '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 31},
    '{1'b1, 32'd7,         32'd7,         64'h0000_0000_0000_0001, 0},
    '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'h7FFF_FFFF_0000_0000, 0}
  };

  initial begin
    int unsigned k, e, extra;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("reset_state", {busy, done, div_zero, hi, lo}, '0);

    issue(1'b0, 32'd7, -32'sd7 + 32'd4, k);
    chk("mult7x-3_busy", busy, 1'b1);
    wait_done("mult7x-3", e);
    chk("mult7x-3_lat", 64'(e - k), 64'(lat(1'b0, 2)));
    chk("mult7x-3_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mult7x-3_busy_at_done", busy, 1'b0);

    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, k);
    wait_done("div_min_by_m1", e);
    chk("div_min_by_m1_res", {hi, lo, div_zero}, {64'h0000_0000_8000_0000, 1'b0});

    issue(1'b1, -32'sd7, 32'd2, k);
    wait_done("div-7by2", e);
    chk("div-7by2_lat", 64'(e - k), 64'(W + 1));
    chk("div-7by2_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(1'b1, 32'd5, 32'd0, k);
    wait_done("div0", e);
    chk("div0_lat", 64'(e - k), 64'd0);
    chk("div0_flags", {done, div_zero, busy}, 3'b110);
    chk("div0_hilo_kept", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    @(negedge clk);
    chk("div0_pulse_end", {done, div_zero}, 2'b00);

    issue(1'b0, 32'd1234, -32'sd5678, k);
    repeat (4) @(negedge clk);
    op = 1'b1; a = 32'd99; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_start", e);
    chk("ignored_start_lat", 64'(e - k), 64'(lat(1'b0, 13)));
    chk("ignored_start_res", {hi, lo}, 64'hFFFF_FFFF_FF95_1644);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk("ignored_start_single_done", 64'(extra), 64'd0);

    issue(1'b0, 32'd12345, 32'h4000_0001, k);
    extra = 0;
    repeat (9) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_state", {busy, done, hi, lo}, '0);
    chk("abort_no_done", 64'(extra), 64'd0);

    issue(1'b0, 32'd2, 32'd3, k);
    wait_done("mult2x3", e);
    chk("mult2x3_lat", 64'(e - k), 64'(lat(1'b0, 2)));
    chk("mult2x3_res", {hi, lo}, 64'd6);

    issue(1'b0, 32'd5, 32'd3, k);
    wait_done("mult5x3", e);
    chk("mult5x3_lat", 64'(e - k), 64'(lat(1'b0, 2)));
    chk("mult5x3_res", {hi, lo}, 64'd15);

    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].av, vecs[i].bv, k);
      wait_done($sformatf("vec%0d", i), e);
      chk($sformatf("vec%0d_lat", i), 64'(e - k), 64'(lat(vecs[i].o, vecs[i].n)));
      chk($sformatf("vec%0d_res", i), {hi, lo}, vecs[i].exp);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
